dmem_responder: RTL and testbench

Memory-side responder for the LSU io_* request/response interface: a word-organised data RAM behind a valid/valid handshake.
Serves full aligned words only; the LSU performs lane rotation, sign extension and misaligned splitting.
Latency is configurable from combinational (0) to multi-cycle, so the LSU's instant and waiting paths are both exercised.
Used as the data-memory model in SoC simulation and as synthesizable on-chip RAM.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_lfsr8.sv | 26 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmem_state_t : responder FSM states (DMEM_IDLE, DMEM_WAIT)
//   - SIZE_*       : LSU access-size codes (the responder ignores them)
//   - LFSR_SEED / LFSR_TAPS and lfsr_next() for the optional random-latency
//     generator (compiled in with DMEM_RAND_LAT_EN)
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_EXTA = 2'b11;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dmem_lfsr8.sv
// ---------------------------------------------------------------------------
// dmem_lfsr8
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter the
// responder latency. Seeds to LFSR_SEED on reset, advances every cycle.
// Ports:
//   clock  in   clock
//   reset  in   asynchronous active-high reset
//   value  out  current LFSR state
// ---------------------------------------------------------------------------
module dmem_lfsr8
    import dmem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-organised data RAM serving the LSU io_* valid/valid handshake.
// Only full aligned words are handled; byte lanes are selected by io_wmask.
// Response latency is LATENCY cycles (0 = same-cycle combinational reply).
// Build option: define DMEM_RAND_LAT_EN to add 0..3 random extra cycles
// per request, drawn from an 8-bit LFSR at acceptance.
// Ports:
//   clock         in   clock
//   reset         in   asynchronous active-high reset
//   io_reqValid   in   request valid, held until io_respValid
//   io_respValid  out  one-cycle pulse completing the transaction
//   io_wen        in   1 = write, 0 = read
//   io_addr       in   byte address; word index = io_addr[AW+1:2]
//   io_wdata      in   lane-aligned write data
//   io_wmask      in   byte-lane write enables
//   io_size       in   access size code (unused by the datapath)
//   io_rdata      out  read word, zero whenever io_respValid = 0
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_reqValid,
    output logic        io_respValid,
    input  logic        io_wen,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wmask,
    input  logic [1:0]  io_size,
    output logic [31:0] io_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]    mem [DEPTH_WORDS];

    dmem_state_t    state;
    logic [15:0]    countdown;
    logic [AW-1:0]  lat_idx;
    logic           lat_wen;
    logic [31:0]    lat_wdata;
    logic [3:0]     lat_wmask;

    logic [AW-1:0]  live_idx;
    logic [1:0]     extra;
    logic           immediate;
    logic           fast_resp;
    logic           wait_resp;
    logic           resp;
    logic [AW-1:0]  sel_idx;
    logic           sel_wen;
    logic [31:0]    sel_wdata;
    logic [3:0]     sel_wmask;

    // Address bits outside the word index and the size code are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{io_size, io_addr[31:AW+2], io_addr[1:0]};

    assign live_idx = io_addr[AW+1:2];

`ifdef DMEM_RAND_LAT_EN
    logic [7:0] lfsr_value;

    dmem_lfsr8 u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_value)
    );

    assign extra = lfsr_value[1:0];
`else
    assign extra = 2'd0;
`endif

    // A request is answered in its own cycle only when the total latency is 0.
    assign immediate = (LATENCY == 0) && (extra == 2'd0);
    assign fast_resp = (state == DMEM_IDLE) && io_reqValid && immediate;
    assign wait_resp = (state == DMEM_WAIT) && (countdown == 16'd0);
    assign resp      = !reset && (fast_resp || wait_resp);

    // Same-cycle replies use live inputs; delayed replies use latched fields.
    assign sel_idx   = fast_resp ? live_idx : lat_idx;
    assign sel_wen   = fast_resp ? io_wen   : lat_wen;
    assign sel_wdata = fast_resp ? io_wdata : lat_wdata;
    assign sel_wmask = fast_resp ? io_wmask : lat_wmask;

    assign io_respValid = resp;
    assign io_rdata     = resp ? mem[sel_idx] : 32'd0;

    // RAM: read is combinational, so a write response returns pre-write data
    // and the new data is visible from the following cycle on.
    always_ff @(posedge clock) begin
        if (resp && sel_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_wmask[b]) begin
                    mem[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= DMEM_IDLE;
            countdown <= 16'd0;
            lat_idx   <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= 32'd0;
            lat_wmask <= 4'd0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (io_reqValid && !immediate) begin
                        lat_idx   <= live_idx;
                        lat_wen   <= io_wen;
                        lat_wdata <= io_wdata;
                        lat_wmask <= io_wmask;
                        countdown <= 16'(LATENCY) + 16'(extra) - 16'd1;
                        state     <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    // Live inputs are deliberately not looked at here.
                    if (countdown != 16'd0) begin
                        countdown <= countdown - 16'd1;
                    end else begin
                        state <= DMEM_IDLE;
                    end
                end
                default: state <= DMEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Four responders (LATENCY 0..3, 1024 words) on a shared clock with private
// request signals and resets. Table vectors, hand-written timing sequences
// and a randomized phase against a per-instance word-array model.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NI = 4;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset      [NI];
    logic        req_valid  [NI];
    logic        wen        [NI];
    logic [31:0] addr       [NI];
    logic [31:0] wdata      [NI];
    logic [3:0]  wmask      [NI];
    logic [1:0]  size       [NI];
    logic        resp_valid [NI];
    logic [31:0] rdata      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .LATENCY     (g)
        ) u_dut (
            .clock        (clock),
            .reset        (reset[g]),
            .io_reqValid  (req_valid[g]),
            .io_respValid (resp_valid[g]),
            .io_wen       (wen[g]),
            .io_addr      (addr[g]),
            .io_wdata     (wdata[g]),
            .io_wmask     (wmask[g]),
            .io_size      (size[g]),
            .io_rdata     (rdata[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [NI][16];

    typedef struct {
        int          inst;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int inst, input int lat);
        bit ok;
        checks++;
`ifdef DMEM_RAND_LAT_EN
        ok = (lat >= inst) && (lat <= inst + 3);
`else
        ok = (lat == inst);
`endif
        if (!ok) begin
            failures++;
            $display("FAIL %s: latency %0d expected %0d (inst %0d)", name, lat, inst, inst);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Entered and left at posedge+1. Latency counts cycles from the request
    // cycle to the cycle in which io_respValid is seen high.
    task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output int lat);
        req_valid[i] = 1'b1;
        wen[i]       = w;
        addr[i]      = a;
        wdata[i]     = d;
        wmask[i]     = m;
        lat          = -1;
        rd           = 32'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (resp_valid[i]) begin
                rd  = rdata[i];
                lat = c;
                break;
            end
            @(posedge clock); #1;
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: inst %0d got no response, required one within 20 cycles", i);
        end
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          seen;
        bit          got;

        for (int i = 0; i < NI; i++) begin
            reset[i]     = 1'b1;
            req_valid[i] = 1'b0;
            wen[i]       = 1'b0;
            addr[i]      = 32'd0;
            wdata[i]     = 32'd0;
            wmask[i]     = 4'd0;
            size[i]      = 2'b10;
        end

        vecs[0]  = '{1, 1'b1, 32'h0000_0010, 32'hAABBCCDD, 4'b1111, 1'b0, 32'h0};
        vecs[1]  = '{1, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b1, 32'hAABBCCDD};
        vecs[2]  = '{1, 1'b1, 32'h0000_0010, 32'h00EE0000, 4'b0100, 1'b0, 32'h0};
        vecs[3]  = '{1, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b1, 32'hAAEECCDD};
        vecs[4]  = '{1, 1'b1, 32'h0000_0010, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0};
        vecs[5]  = '{1, 1'b0, 32'h0000_0013, 32'h0,        4'b0000, 1'b1, 32'hAAEECCDD};
        vecs[6]  = '{1, 1'b1, 32'h0000_1004, 32'h12345678, 4'b1111, 1'b0, 32'h0};
        vecs[7]  = '{1, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 1'b1, 32'h12345678};
        vecs[8]  = '{0, 1'b1, 32'h0000_0010, 32'hAABBCCDD, 4'b1111, 1'b0, 32'h0};
        vecs[9]  = '{0, 1'b1, 32'h0000_0010, 32'h00EE0000, 4'b0100, 1'b0, 32'h0};
        vecs[10] = '{0, 1'b0, 32'h0000_0010, 32'h0,        4'b0000, 1'b1, 32'hAAEECCDD};
        vecs[11] = '{2, 1'b1, 32'h0000_0010, 32'h11111111, 4'b1111, 1'b0, 32'h0};
        vecs[12] = '{2, 1'b1, 32'h0000_0014, 32'h22222222, 4'b1111, 1'b0, 32'h0};
        vecs[13] = '{3, 1'b1, 32'h0000_0020, 32'h0BADBEEF, 4'b1111, 1'b0, 32'h0};
        vecs[14] = '{3, 1'b0, 32'h0000_0020, 32'h0,        4'b0000, 1'b1, 32'h0BADBEEF};
        vecs[15] = '{2, 1'b1, 32'h0000_1FFC, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
        vecs[16] = '{2, 1'b0, 32'hF000_7FFC, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_resp_valid_%0d", i), {31'd0, resp_valid[i]}, 32'd0);
            check($sformatf("reset_rdata_%0d", i), rdata[i], 32'd0);
        end
        @(posedge clock); #1;
        for (int i = 0; i < NI; i++) reset[i] = 1'b0;

        // Table vectors, issued back to back
        for (int v = 0; v < 17; v++) begin
            txn(vecs[v].inst, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].m, rd, lat);
            check_lat($sformatf("vec%0d_latency", v), vecs[v].inst, lat);
            if (vecs[v].chk) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
        end

        // LATENCY=0: same-cycle read, then zero output while idle
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, rd, lat);
        check_lat("lat0_read_latency", 0, lat);
        check("lat0_read_rdata", rd, 32'hAAEECCDD);
        @(negedge clock);
        check("lat0_idle_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        check("lat0_idle_rdata", rdata[0], 32'd0);
        @(posedge clock); #1;

        // LATENCY=2: address switches in the response cycle, request stays up
        req_valid[2] = 1'b1;
        wen[2]       = 1'b0;
        addr[2]      = 32'h0000_0010;
        wmask[2]     = 4'd0;
        got          = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (resp_valid[2]) begin
                addr[2] = 32'h0000_0014;
                #1;
                check("misalign_first_rdata", rdata[2], 32'h11111111);
                check_lat("misalign_first_latency", 2, c);
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL misalign_first_timeout: no response, required one within 20 cycles");
        end
        @(posedge clock); #1;
        txn(2, 1'b0, 32'h0000_0014, 32'h0, 4'b0000, rd, lat);
        check_lat("misalign_second_latency", 2, lat);
        check("misalign_second_rdata", rd, 32'h22222222);

        // LATENCY=3: reset one cycle after acceptance aborts the write
        req_valid[3] = 1'b1;
        wen[3]       = 1'b1;
        addr[3]      = 32'h0000_0020;
        wdata[3]     = 32'hCAFEF00D;
        wmask[3]     = 4'b1111;
        @(posedge clock); #1;
        reset[3]     = 1'b1;
        req_valid[3] = 1'b0;
        seen         = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (resp_valid[3]) seen++;
            @(posedge clock); #1;
            if (c == 0) reset[3] = 1'b0;
        end
        check("abort_no_resp_pulses", seen, 0);
        txn(3, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, rd, lat);
        check_lat("abort_read_latency", 3, lat);
        check("abort_read_rdata", rd, 32'h0BADBEEF);

        // Randomized phase against the word-array model
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 16; k++) begin
                model[i][k] = $urandom;
                txn(i, 1'b1, 32'(k) << 2, model[i][k], 4'b1111, rd, lat);
                check_lat($sformatf("init%0d_%0d_latency", i, k), i, lat);
            end
            for (int n = 0; n < 100; n++) begin
                int          idx;
                logic [31:0] r;
                logic [31:0] a;
                logic [31:0] d;
                logic [3:0]  m;
                bit          w;
                idx = $urandom_range(0, 15);
                r   = $urandom;
                a   = (r & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
                w   = 1'($urandom_range(0, 1));
                d   = $urandom;
                m   = 4'($urandom_range(0, 15));
                txn(i, w, a, d, m, rd, lat);
                check_lat($sformatf("rand%0d_%0d_latency", i, n), i, lat);
                if (w) model[i][idx] = merge(model[i][idx], d, m);
                else   check($sformatf("rand%0d_%0d_rdata", i, n), rd, model[i][idx]);
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clock);
                    check($sformatf("rand%0d_%0d_idle_valid", i, n), {31'd0, resp_valid[i]}, 32'd0);
                    check($sformatf("rand%0d_%0d_idle_rdata", i, n), rdata[i], 32'd0);
                    @(posedge clock); #1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
